arp_req_tx: RTL

//  Builds broadcast ARP request frames for the ARP aging logic, the other end of its tx_req_* interface.

---
 rtl/arp_req_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/arp_req_tx.sv
// arp_req_tx: queues (netport, ip) ARP resolve requests from the aging logic and
// serialises each one as a 60-byte broadcast Ethernet/ARP request frame on an
// 8-bit stream toward the MAC TX arbiter.
//
// Stream handshake: a byte transfers on a cycle where tx_valid and tx_ready are
// both high. Once tx_valid rises it stays high, and tx_data/tx_sof/tx_eof/tx_netport
// stay unchanged, until the byte is accepted. tx_ready may change freely.
module arp_req_tx #(
    parameter int QDEPTH_LOG2 = 2,
    parameter int IFG_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [23:0] req_netport,
    input  logic [31:0] req_ip,
    input  logic        req_en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    input  logic        tx_ready,
    output logic [23:0] tx_netport,
    output logic        busy,
    output logic [15:0] drop_cnt,
    output logic [1:0]  dbg_state
);

    localparam int QDEPTH = 1 << QDEPTH_LOG2;
    localparam int GW     = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
    // GAP lasts IFG_CYCLES-1 cycles; the LOAD cycle that follows supplies the
    // last idle cycle, so back-to-back frames are separated by IFG_CYCLES idles.
    localparam logic [GW-1:0] GAP_LOAD = GW'(IFG_CYCLES - 2);
    localparam logic [5:0]    LAST_IDX = 6'd59;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // request queue: {netport, ip}
    logic [55:0]            q_mem [QDEPTH];
    logic [QDEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [QDEPTH_LOG2:0]   q_cnt;
    logic                   q_empty, q_full;
    logic                   req_valid, push, pop, drop;
    logic [55:0]            q_head;

    // frame context latched at LOAD
    logic [31:0]  ip_r;
    logic [47:0]  mac_r;
    logic [31:0]  lip_r;
    logic [5:0]   idx;
    logic [GW-1:0] gap_cnt;

    logic         accept, last_accept;
    logic [479:0] frame;
    logic [5:0]   rev_idx;
    logic [8:0]   bit_base;

    assign q_empty   = (q_cnt == '0);
    assign q_full    = (int'(q_cnt) == QDEPTH);
    assign req_valid = req_en && (req_ip != 32'd0);
    assign pop       = (state == LOAD) && !q_empty;
    // a full queue still takes the request when the head leaves this cycle
    assign push      = req_valid && (!q_full || pop);
    assign drop      = req_valid && q_full && !pop;
    assign q_head    = q_mem[rd_ptr];

    assign accept      = (state == SEND) && tx_ready;
    assign last_accept = accept && (idx == LAST_IDX);

    // queue storage, written on push (no reset needed: guarded by q_cnt)
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= {req_netport, req_ip};
        end
    end

    // queue pointers and occupancy; pointers wrap naturally modulo depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      q_cnt <= q_cnt + 1'b1;
            else if (!push && pop) q_cnt <= q_cnt - 1'b1;
        end
    end

    // saturating count of requests lost to a full queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 16'd0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; a request arriving this cycle counts as pending so
    // the first byte appears two cycles after the strobe
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!q_empty || req_valid) state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: if (last_accept) state_nxt = GAP;
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = (!q_empty || req_valid) ? LOAD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // byte index, inter-frame gap counter and latched frame context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 6'd0;
            gap_cnt    <= '0;
            ip_r       <= 32'd0;
            tx_netport <= 24'd0;
            mac_r      <= 48'd0;
            lip_r      <= 32'd0;
        end else begin
            if (state == LOAD) begin
                idx        <= 6'd0;
                ip_r       <= q_head[31:0];
                tx_netport <= q_head[55:32];
                mac_r      <= local_mac;
                lip_r      <= local_ip;
            end else if (accept && (idx != LAST_IDX)) begin
                idx <= idx + 6'd1;
            end
            if (last_accept) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // whole frame laid out MSB-first; byte idx sits at bits [8*(59-idx) +: 8]
    assign frame = {48'hFFFF_FFFF_FFFF, mac_r, 16'h0806, 16'h0001, 16'h0800,
                    8'h06, 8'h04, 16'h0001, mac_r, lip_r, 48'd0, ip_r, 144'd0};
    assign rev_idx  = LAST_IDX - idx;
    assign bit_base = {rev_idx, 3'b000};

    // stream outputs, all forced low outside SEND
    always_comb begin
        tx_valid = (state == SEND);
        tx_sof   = tx_valid && (idx == 6'd0);
        tx_eof   = tx_valid && (idx == LAST_IDX);
        tx_data  = tx_valid ? frame[bit_base +: 8] : 8'd0;
    end

    assign busy      = (state != IDLE) || !q_empty;
    assign dbg_state = state;

endmodule
